// File: rtl/uart_pkg.sv
// Shared UART constants: port map, status layout, receiver states.
// Used by both the receive and transmit paths.
package uart_pkg;

   localparam int unsigned CLKS_PER_BIT_DEF = 434;

   localparam logic [7:0] PORT_RXDATA = 8'd9;
   localparam logic [7:0] PORT_STATUS = 8'd11;

   localparam int unsigned ST_VALID   = 0;
   localparam int unsigned ST_OVERRUN = 1;
   localparam int unsigned ST_FERR    = 2;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

   function automatic logic [7:0] status_byte(
      input logic ferr,
      input logic ovr,
      input logic vld
   );
      logic [7:0] s;
      s             = '0;
      s[ST_VALID]   = vld;
      s[ST_OVERRUN] = ovr;
      s[ST_FERR]    = ferr;
      return s;
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 serial receiver: synchronizer, bit-timing FSM and shift register.
// Emits one-clk done/ferr pulses when a frame's stop bit is sampled.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx_i,
   output logic       done_o,
   output logic       ferr_o,
   output logic [7:0] data_o
);

   localparam int unsigned CW =
      (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_MAX = CW'(CLKS_PER_BIT / 2 - 1);

   logic          s1_q, s2_q, s3_q;
   rx_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          done_q, done_d;
   logic          ferr_q, ferr_d;

   // s3_q is the previous synchronized sample, used only for edge detect
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
         s3_q <= 1'b1;
      end else begin
         s1_q <= rx_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
      unique case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (s3_q && !s2_q) begin
               state_d = RX_START;
               bit_d   = '0;
            end
         end
         RX_START: begin
            if (cnt_q == HALF_MAX) begin
               cnt_d   = '0;
               state_d = s2_q ? RX_IDLE : RX_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt_q == CNT_MAX) begin
               cnt_d   = '0;
               shift_d = {s2_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = RX_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt_q == CNT_MAX) begin
               cnt_d   = '0;
               done_d  = s2_q;
               ferr_d  = !s2_q;
               state_d = RX_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   assign done_o = done_q;
   assign ferr_o = ferr_q;
   assign data_o = shift_q;

endmodule

// File: rtl/uart_rx_io.sv
// UART receiver on the IO bus: port 9 data, port 11 status/clear.
// Flags and the holding register live here; bit timing in uart_rx_core.
module uart_rx_io
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic      [7:0] Address,
   inout  wire logic [7:0] Data,
   input  logic            IORQ,
   input  logic            RD,
   input  logic            WR,
   input  logic            uart_rx
);

   logic       core_done, core_ferr;
   logic [7:0] core_data;

   uart_rx_core #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_core (
      .clk_i (clk),
      .rst_ni(reset),
      .rx_i  (uart_rx),
      .done_o(core_done),
      .ferr_o(core_ferr),
      .data_o(core_data)
   );

   logic rd_any, rd_data_sel, rd_stat_sel, wr_stat_sel;
   logic rd9_first, wr11_first;
   logic rd9_q, wr11_q;
   logic [7:0] data_q, data_d;
   logic valid_q, valid_d;
   logic ovr_q, ovr_d;
   logic ferr_q, ferr_d;
   logic [7:0] rd_mux;

   assign rd_any      = IORQ && RD && !WR;
   assign rd_data_sel = rd_any && (Address == PORT_RXDATA);
   assign rd_stat_sel = rd_any && (Address == PORT_STATUS);
   assign wr_stat_sel = IORQ && WR && !RD && (Address == PORT_STATUS);

   // Side effects fire once per bus cycle, however long the strobe is held
   assign rd9_first  = rd_data_sel && !rd9_q;
   assign wr11_first = wr_stat_sel && !wr11_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd9_q   <= 1'b0;
         wr11_q  <= 1'b0;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         rd9_q   <= rd_data_sel;
         wr11_q  <= wr_stat_sel;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
      end
   end

   // A new byte landing on the read's first clk replaces the one being read
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      ferr_d  = ferr_q;
      if (rd9_first) valid_d = 1'b0;
      if (wr11_first) begin
         ovr_d  = 1'b0;
         ferr_d = 1'b0;
      end
      if (core_done) begin
         data_d  = core_data;
         valid_d = 1'b1;
         if (valid_q && !rd9_first) ovr_d = 1'b1;
      end
      if (core_ferr) ferr_d = 1'b1;
   end

   always_comb begin
      rd_mux = 8'h00;
      if (rd_data_sel) rd_mux = data_q;
      else if (rd_stat_sel) rd_mux = status_byte(ferr_q, ovr_q, valid_q);
   end

   assign Data = (rd_data_sel || rd_stat_sel) ? rd_mux : 8'hzz;

endmodule

// File: tb/tb_uart_rx_io.sv
// Bench for uart_rx_io: serial frames in, IO-bus reads checked
// against a queue of bytes pushed as each frame is driven.
module tb_uart_rx_io;

   localparam int CPB = 434;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] Address = 8'h00;
   wire  [7:0] Data;
   logic       IORQ = 1'b0;
   logic       RD = 1'b0;
   logic       WR = 1'b0;
   logic       uart_rx = 1'b1;

   int n_chk = 0;
   int n_pass = 0;
   logic [7:0] exp_q[$];

   always #10 clk = ~clk;

   uart_rx_io #(
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .Address(Address),
      .Data   (Data),
      .IORQ   (IORQ),
      .RD     (RD),
      .WR     (WR),
      .uart_rx(uart_rx)
   );

   task automatic check(input string tag, input logic [7:0] got,
                        input logic [7:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
   endtask

   task automatic bus_rd(input logic [7:0] a, output logic [7:0] d);
      @(negedge clk);
      Address = a;
      IORQ = 1'b1;
      RD = 1'b1;
      #1 d = Data;
      @(negedge clk);
      IORQ = 1'b0;
      RD = 1'b0;
      Address = 8'h00;
   endtask

   task automatic bus_wr11();
      @(negedge clk);
      Address = 8'd11;
      IORQ = 1'b1;
      WR = 1'b1;
      @(negedge clk);
      IORQ = 1'b0;
      WR = 1'b0;
      Address = 8'h00;
   endtask

   task automatic rd_stat(input string tag, input logic [7:0] exp);
      logic [7:0] d;
      bus_rd(8'd11, d);
      check(tag, d, exp);
   endtask

   // Unread bytes are overwritten in the DUT, so only the newest counts
   task automatic rd_byte(input string tag);
      logic [7:0] d, e;
      bus_rd(8'd9, d);
      while (exp_q.size() > 1) void'(exp_q.pop_front());
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      check(tag, d, e);
   endtask

   task automatic send(input logic [7:0] b, input logic stop,
                       input bit push);
      if (push) exp_q.push_back(b);
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = stop;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      logic [7:0] d;
      repeat (3) @(negedge clk);
      bus_rd(8'd11, d);
      check("rst_status", d, 8'h00);
      bus_rd(8'd9, d);
      check("rst_data", d, 8'h00);
      reset = 1'b1;
      repeat (5) @(negedge clk);

      send(8'h41, 1'b1, 1'b1);
      rd_stat("s41_valid", 8'h01);
      rd_stat("s41_valid_again", 8'h01);
      rd_byte("s41_data");
      rd_stat("s41_cleared", 8'h00);

      send(8'h55, 1'b1, 1'b1);
      send(8'hAA, 1'b1, 1'b1);
      rd_stat("ovr_status", 8'h03);
      bus_wr11();
      rd_stat("ovr_after_clr", 8'h01);
      rd_byte("ovr_data");
      rd_stat("ovr_final", 8'h00);

      send(8'h3C, 1'b0, 1'b0);
      rd_stat("ferr_status", 8'h04);
      bus_wr11();
      rd_stat("ferr_after_clr", 8'h00);

      @(negedge clk);
      uart_rx = 1'b0;
      repeat (100) @(negedge clk);
      uart_rx = 1'b1;
      repeat (CPB) @(negedge clk);
      rd_stat("glitch_status", 8'h00);
      send(8'h7E, 1'b1, 1'b1);
      rd_stat("glitch_next_valid", 8'h01);
      rd_byte("glitch_next_data");

      fork
         send(8'hF0, 1'b1, 1'b0);
         begin
            repeat (5 * CPB + CPB / 2 + 2) @(negedge clk);
            reset = 1'b0;
            repeat (3) @(negedge clk);
            reset = 1'b1;
         end
      join
      repeat (CPB) @(negedge clk);
      rd_stat("midrst_status", 8'h00);
      bus_rd(8'd9, d);
      check("midrst_data", d, 8'h00);
      send(8'hC3, 1'b1, 1'b1);
      rd_stat("post_rst_valid", 8'h01);
      rd_byte("post_rst_data");
      rd_stat("post_rst_clear", 8'h00);

      send(8'h5A, 1'b1, 1'b1);
      fork
         send(8'h12, 1'b1, 1'b1);
         begin
            logic [7:0] d0, d1;
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 12 * CPB && !hit; i++) begin
               @(negedge clk);
               if (dut.u_core.done_o === 1'b1) hit = 1'b1;
            end
            if (hit) begin
               Address = 8'd9;
               IORQ = 1'b1;
               RD = 1'b1;
               #1 d0 = Data;
               check("race_old_byte", d0, exp_q.pop_front());
               @(negedge clk);
               #1 d1 = Data;
               check("race_new_byte", d1, exp_q[0]);
               repeat (3) @(negedge clk);
               IORQ = 1'b0;
               RD = 1'b0;
               Address = 8'h00;
            end else begin
               check("race_timeout", 8'h00, 8'h01);
            end
         end
      join
      rd_stat("race_status", 8'h01);
      rd_byte("race_data");
      rd_stat("race_final", 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_rx_io.md
UART_RX_IO -- requirements
Module: uart_rx_io

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200).
REQ-002 clk  input  1  system clock, 50 MHz, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 Address  input  8  IO port address.
REQ-005 Data  inout  8  IO data bus; driven only during a decoded read, else 8'hzz.
REQ-006 IORQ  input  1  IO request, positive logic.
REQ-007 RD  input  1  read strobe, positive logic.
REQ-008 WR  input  1  write strobe, positive logic.
REQ-009 uart_rx  input  1  UART receive line, idle high, asynchronous to clk.

Function
REQ-010 Port map SHALL be: read 9 = received byte; read 11 = status {5'b0, framing_err, overrun, rx_valid}; write 11 = clear error flags.
REQ-011 Read decode SHALL be Address match && IORQ==1 && RD==1 && WR==0; write decode Address match && IORQ==1 && RD==0 && WR==1.
REQ-012 Data SHALL be driven combinationally for the whole decoded read; no read latency.
REQ-013 uart_rx SHALL pass through a 2-flop synchronizer before any use; sampling latency from pin is 2 clks.
REQ-014 Receiver FSM states: IDLE, START, DATA, STOP.
REQ-015 IDLE -> START on synchronized high-to-low transition; bit counter cleared.
REQ-016 START: at CLKS_PER_BIT/2 clks (mid start bit), line low -> DATA; line high -> IDLE (glitch rejected, no flags touched).
REQ-017 DATA: sample every CLKS_PER_BIT clks at mid-bit, 8 bits LSB first into a shift register; after bit 7 -> STOP.
REQ-018 STOP: sample once CLKS_PER_BIT clks after bit 7; always -> IDLE on the next clk.
REQ-019 Stop sample high: byte SHALL load into rx_data, rx_valid set; if rx_valid was already 1, overrun set and rx_data overwritten with the new byte.
REQ-020 Stop sample low: framing_err set, rx_data and rx_valid unchanged.
REQ-021 Bit-time counter SHALL be wide enough for CLKS_PER_BIT-1 and reload on every sample; no cumulative drift beyond integer rounding.
REQ-022 rx_valid SHALL clear on the first clk of a decoded read of port 9 (edge-detected; a multi-cycle read clears once).
REQ-023 Simultaneous byte completion and first clk of port-9 read: rx_valid stays 1, rx_data takes new byte, overrun not set; the read returns the old byte during that clk.
REQ-024 Write to port 11 SHALL clear overrun and framing_err on the first clk of the decoded write, Data value ignored; a same-clk error event wins (flag stays set).
REQ-025 Reading port 11 SHALL have no side effects.
REQ-026 FSM keeps receiving regardless of rx_valid (no flow control).

Reset
REQ-027 reset low SHALL asynchronously force: FSM IDLE, counters 0, shift register 0, rx_data 8'h00, rx_valid 0, overrun 0, framing_err 0, synchronizer flops 1 (idle).
REQ-028 Reset asserted mid-frame SHALL abandon the frame; after release a new start edge is required before reception resumes.
REQ-029 Data SHALL remain high-impedance during reset unless a decoded read is active, which then returns 8'h00 or status 8'h00.

Structure
REQ-030 Serial receiver (synchronizer, FSM, counters, shift register, done/ferr pulses) SHALL be sub-module uart_rx_core; uart_rx_io holds the decode, registers and flags.
REQ-031 Port addresses (9, 11), status bit positions and the default CLKS_PER_BIT SHALL be constants in the shared uart package used by the transmit path.

Verification
REQ-032 Send 8'h41, 8N1 at CLKS_PER_BIT=434 -> status reads 8'h01, port 9 reads 8'h41, status then reads 8'h00.
REQ-033 Send 8'h55 then 8'hAA without reading -> status 8'h03, port 9 returns 8'hAA; write 11 -> status 8'h01.
REQ-034 Frame 8'h3C with stop bit low -> status 8'h04, rx_valid 0; write 11 -> 8'h00.
REQ-035 Low pulse of 100 clks on idle line -> no state change, status 8'h00, next byte 8'h7E received correctly.
REQ-036 Assert reset during bit 4 of a frame -> all flags 0; following frame 8'hC3 received as 8'hC3.
REQ-037 Hold port-9 read 5 clks while byte 8'h12 completes on its first clk -> Data 8'hxx old byte then 8'h12, rx_valid 1, overrun 0.
